cpu_fifo_io: RTL and testbench

Parametrised FIFO I/O unit for the CPU core, generalising the single request-FIFO / single read-FIFO port pair to NUM_CH independent channels. The core issues one IN (dequeue) or OUT (enqueue) operation at a time; the block stalls the core while the operation is outstanding. It adds non-blocking mode, a programmable timeout and a completion status code. It sits between the core's datapath/decoder and the external per-channel FIFOs.

---
 rtl/cpu_fifo_io.sv | 148 ++++++++++++++
 tb/tb_cpu_fifo_io.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpu_fifo_io.sv
// Multi-channel FIFO I/O unit for the CPU core: one IN (dequeue) or OUT (enqueue)
// operation in flight, with stall, non-blocking mode, timeout and completion status.
module cpu_fifo_io #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     op_valid,
  input  logic                     op_write,
  input  logic [CH_W-1:0]          op_ch,
  input  logic [DATA_W-1:0]        op_data,
  input  logic                     op_nonblock,
  input  logic [TIMEOUT_W-1:0]     timeout_limit,
  output logic                     stall,
  output logic                     done,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               status,
  input  logic [NUM_CH*DATA_W-1:0] req_fifo_data,
  input  logic [NUM_CH-1:0]        req_fifo_rdempty,
  output logic [NUM_CH-1:0]        req_fifo_deq,
  output logic [DATA_W-1:0]        read_fifo_data_in,
  input  logic [NUM_CH-1:0]        read_fifo_wrfull,
  output logic [NUM_CH-1:0]        read_fifo_enq
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADCH   = 2'b11;

  logic [1:0]           state_q, state_d;
  logic                 write_q, write_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 nb_q, nb_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [1:0]           status_q, status_d;

  logic                 sel_empty, sel_full, ch_ok, ready, xfer;
  logic [DATA_W-1:0]    sel_data;
  logic [TIMEOUT_W:0]   cnt_inc;

  // Channel select by compare, so an out-of-range op_ch never indexes past the vectors.
  always_comb begin
    sel_empty = 1'b1;
    sel_full  = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_empty = req_fifo_rdempty[i];
        sel_full  = read_fifo_wrfull[i];
        sel_data  = req_fifo_data[i*DATA_W +: DATA_W];
      end
    end
    ch_ok   = ({1'b0, ch_q} < (CH_W+1)'(NUM_CH));
    ready   = write_q ? !sel_full : !sel_empty;
    xfer    = (state_q == S_BUSY) && ch_ok && ready;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    ch_d      = ch_q;
    data_d    = data_q;
    nb_d      = nb_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE: if (op_valid) begin
        write_d = op_write;
        ch_d    = op_ch;
        data_d  = op_data;
        nb_d    = op_nonblock;
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!ch_ok) begin
          status_d = ST_BADCH;
          state_d  = S_DONE;
        end else if (ready) begin
          if (!write_q) rd_data_d = sel_data;
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (nb_q) begin
          status_d = ST_MISS;
          state_d  = S_DONE;
        end else begin
          // Saturating wait counter; a saturated count can never match a nonzero limit.
          if (cnt_q != '1) cnt_d = cnt_inc[TIMEOUT_W-1:0];
          if (timeout_limit != '0 && cnt_inc == {1'b0, timeout_limit}) begin
            status_d = ST_TIMEOUT;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      ch_q      <= '0;
      data_q    <= '0;
      nb_q      <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      nb_q      <= nb_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    req_fifo_deq  = '0;
    read_fifo_enq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_fifo_deq[i]  = xfer && !write_q && (ch_q == CH_W'(i));
      read_fifo_enq[i] = xfer &&  write_q && (ch_q == CH_W'(i));
    end
  end

  // Stall is gated by rstn so it drops immediately while reset is held, even with op_valid high.
  assign stall             = rstn && (((state_q == S_IDLE) && op_valid) || (state_q == S_BUSY));
  assign done              = (state_q == S_DONE);
  assign rd_data           = rd_data_q;
  assign status            = status_q;
  assign read_fifo_data_in = data_q;
endmodule

// File: tb/tb_cpu_fifo_io.sv
// Directed bench for cpu_fifo_io: a 4-channel instance plus a 3-channel one for the bad-channel case.
module tb_cpu_fifo_io;
  logic        clk = 1'b0;
  logic        rstn;
  logic        op_valid, op_valid3, op_write, op_nonblock;
  logic [1:0]  op_ch;
  logic [31:0] op_data;
  logic [7:0]  timeout_limit;

  logic        stall4, done4, stall3, done3;
  logic [31:0] rd_data4, rd_data3, bus4, bus3;
  logic [1:0]  status4, status3;
  logic [127:0] req_data;
  logic [95:0]  req_data3;
  logic [3:0]  rdempty, wrfull, deq4, enq4;
  logic [2:0]  rdempty3, wrfull3, deq3, enq3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_fifo_io #(.DATA_W(32), .NUM_CH(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_write(op_write), .op_ch(op_ch),
    .op_data(op_data), .op_nonblock(op_nonblock), .timeout_limit(timeout_limit),
    .stall(stall4), .done(done4), .rd_data(rd_data4), .status(status4),
    .req_fifo_data(req_data), .req_fifo_rdempty(rdempty), .req_fifo_deq(deq4),
    .read_fifo_data_in(bus4), .read_fifo_wrfull(wrfull), .read_fifo_enq(enq4));

  cpu_fifo_io #(.DATA_W(32), .NUM_CH(3), .TIMEOUT_W(8)) dut3 (
    .clk(clk), .rstn(rstn), .op_valid(op_valid3), .op_write(op_write), .op_ch(op_ch),
    .op_data(op_data), .op_nonblock(op_nonblock), .timeout_limit(timeout_limit),
    .stall(stall3), .done(done3), .rd_data(rd_data3), .status(status3),
    .req_fifo_data(req_data3), .req_fifo_rdempty(rdempty3), .req_fifo_deq(deq3),
    .read_fifo_data_in(bus3), .read_fifo_wrfull(wrfull3), .read_fifo_enq(enq3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and watch it until done. Cycle 0 is the op_valid cycle; from cycle rdy
  // onward the target channel reads as ready (rdy<0: never). Returns the done cycle,
  // the total strobe bits seen, the last strobe mask and the data bus at that strobe.
  task automatic run_op(input bit s3, input bit w, input logic [1:0] ch, input logic [31:0] d,
                        input bit nb, input int rdy, output int dc, output int ns,
                        output logic [3:0] mk, output logic [31:0] bus);
    logic [3:0] st;
    int sb = 0;
    dc = -1; ns = 0; mk = '0; bus = '0;
    op_write = w; op_ch = ch; op_data = d; op_nonblock = nb;
    if (s3) op_valid3 = 1'b1; else op_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (rdy >= 0 && c >= rdy) begin
        if (s3) begin rdempty3[ch] = 1'b0; wrfull3[ch] = 1'b0; end
        else    begin rdempty[ch]  = 1'b0; wrfull[ch]  = 1'b0; end
      end
      #1;
      st = s3 ? {1'b0, deq3 | enq3} : (deq4 | enq4);
      ns += $countones(st);
      if (st != '0) begin mk = st; bus = s3 ? bus3 : bus4; end
      if (s3 ? done3 : done4) begin
        dc = c;
        if (s3 ? stall3 : stall4) sb++;
        op_valid = 1'b0; op_valid3 = 1'b0;
        break;
      end
      if (!(s3 ? stall3 : stall4)) sb++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op_valid3 = 1'b0;
    chk("stall_profile", sb, 0);
    @(posedge clk); #1;
  endtask

  int dc, ns;
  logic [3:0]  mk;
  logic [31:0] bus;

  initial begin
    rstn = 1'b0; op_valid = 1'b0; op_valid3 = 1'b0; op_write = 1'b0; op_ch = '0;
    op_data = '0; op_nonblock = 1'b0; timeout_limit = '0;
    req_data  = {32'hC0FFEE03, 32'hDEADBEEF, 32'h00000001, 32'hA5A5A5A5};
    req_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    rdempty = '1; wrfull = '0; rdempty3 = '1; wrfull3 = '0;
    #3;
    chk("rst_stall", stall4, 0);
    chk("rst_done", done4, 0);
    chk("rst_strobes", {deq4, enq4}, 0);
    chk("rst_rd_data", rd_data4, 0);
    chk("rst_status", status4, 0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    // IN ch2, head ready immediately
    rdempty[2] = 1'b0;
    run_op(0, 0, 2'd2, 32'h0, 0, 0, dc, ns, mk, bus);
    chk("in2_done_cyc", dc, 2);
    chk("in2_strobes", ns, 1);
    chk("in2_mask", mk, 4'b0100);
    chk("in2_rd_data", rd_data4, 32'hDEADBEEF);
    chk("in2_status", status4, 0);

    // OUT ch1 blocked by full for cycles 0-4
    wrfull[1] = 1'b1;
    run_op(0, 1, 2'd1, 32'h12345678, 0, 5, dc, ns, mk, bus);
    chk("out1_done_cyc", dc, 6);
    chk("out1_strobes", ns, 1);
    chk("out1_mask", mk, 4'b0010);
    chk("out1_bus", bus, 32'h12345678);
    chk("out1_status", status4, 0);
    chk("out1_rd_hold", rd_data4, 32'hDEADBEEF);

    // non-blocking IN on empty ch0
    rdempty[0] = 1'b1;
    run_op(0, 0, 2'd0, 32'h0, 1, -1, dc, ns, mk, bus);
    chk("nb_done_cyc", dc, 2);
    chk("nb_strobes", ns, 0);
    chk("nb_status", status4, 1);
    chk("nb_rd_hold", rd_data4, 32'hDEADBEEF);

    // blocking IN ch3 with limit 3: timeout, then ready exactly on the timeout cycle
    timeout_limit = 8'd3;
    rdempty[3] = 1'b1;
    run_op(0, 0, 2'd3, 32'h0, 0, -1, dc, ns, mk, bus);
    chk("to_done_cyc", dc, 4);
    chk("to_strobes", ns, 0);
    chk("to_status", status4, 2);
    chk("to_rd_hold", rd_data4, 32'hDEADBEEF);
    rdempty[3] = 1'b1;
    run_op(0, 0, 2'd3, 32'h0, 0, 3, dc, ns, mk, bus);
    chk("race_done_cyc", dc, 4);
    chk("race_strobes", ns, 1);
    chk("race_mask", mk, 4'b1000);
    chk("race_status", status4, 0);
    chk("race_rd_data", rd_data4, 32'hC0FFEE03);
    timeout_limit = '0;

    // 3-channel instance: ch3 is out of range, then OUT ch2
    run_op(1, 0, 2'd3, 32'h0, 0, -1, dc, ns, mk, bus);
    chk("badch_done_cyc", dc, 2);
    chk("badch_strobes", ns, 0);
    chk("badch_status", status3, 3);
    run_op(1, 1, 2'd2, 32'hCAFEF00D, 0, 0, dc, ns, mk, bus);
    chk("ch2_3_done_cyc", dc, 2);
    chk("ch2_3_mask", mk, 4'b0100);
    chk("ch2_3_bus", bus, 32'hCAFEF00D);
    chk("ch2_3_status", status3, 0);

    // reset while BUSY, with the channel turning ready at the same moment
    rdempty[0] = 1'b1;
    op_write = 1'b0; op_ch = 2'd0; op_nonblock = 1'b0; op_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_stall", stall4, 1);
    rdempty[0] = 1'b0; rstn = 1'b0;
    #1;
    chk("mid_rst_stall", stall4, 0);
    chk("mid_rst_deq", deq4, 0);
    chk("mid_rst_done", done4, 0);
    chk("mid_rst_rd_data", rd_data4, 0);
    op_valid = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;
    run_op(0, 0, 2'd0, 32'h0, 0, 0, dc, ns, mk, bus);
    chk("post_rst_done_cyc", dc, 2);
    chk("post_rst_mask", mk, 4'b0001);
    chk("post_rst_rd_data", rd_data4, 32'hA5A5A5A5);
    chk("post_rst_status", status4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
